// File: rtl/uart_prog_loader.sv
// UART program loader: receives 8N1 bytes, packs them little-endian into
// 32-bit instruction words and writes them to consecutive imem addresses.
// The end-of-program marker word stops loading and releases the core reset.
//
// rx state | meaning
// ---------+-----------------------------------------------------------
// RX_IDLE  | line idle, waiting for a synchronised 1->0 edge
// RX_START | half-bit wait, then start-bit confirmation (high = glitch)
// RX_DATA  | eight data bits, LSB first, one every CLKS_PER_BIT cycles
// RX_STOP  | stop-bit sample; high = byte valid, low = frame error
//
// ld state | meaning
// ---------+-----------------------------------------------------------
// LD_LOAD  | accepting bytes, writing completed words
// LD_DONE  | marker seen or memory full; bytes ignored until restart_i
module uart_prog_loader #(
  parameter int          CLKS_PER_BIT = 347,
  parameter int          ADDR_W       = 10,
  parameter logic [31:0] EOP_WORD     = 32'h0000_0FFF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              rx_i,
  input  logic              restart_i,
  output logic              prog_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              prog_done_o,
  output logic              core_rst_no,
  output logic              frame_err_o,
  output logic              overflow_o
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0]  C_FULL   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  C_HALF   = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {LD_LOAD, LD_DONE} ld_state_t;

  logic             r_rx_s1, r_rx_s2, r_rx_prev;
  rx_state_t        r_rx_state;
  logic [CNT_W-1:0] r_tmr;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_byte_vld;
  logic             r_frame_bad;

  ld_state_t        r_ld_state;
  logic [1:0]       r_byte_cnt;
  logic [23:0]      r_word;
  logic [31:0]      w_word_full;

  // Bring the asynchronous line into the clock domain and keep one history bit for edge detect.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= rx_i;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  // 8N1 receiver; timer is a down-counter sampling the line at terminal count.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_rx_state  <= RX_IDLE;
      r_tmr       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_byte_vld  <= 1'b0;
      r_frame_bad <= 1'b0;
    end else begin
      r_byte_vld  <= 1'b0;
      r_frame_bad <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_prev && !r_rx_s2) begin
            r_rx_state <= RX_START;
            r_tmr      <= C_HALF;
          end
        end
        RX_START: begin
          if (r_tmr != '0) begin
            r_tmr <= r_tmr - CNT_W'(1);
          end else if (r_rx_s2) begin
            r_rx_state <= RX_IDLE;
          end else begin
            r_rx_state <= RX_DATA;
            r_tmr      <= C_FULL;
            r_bit_idx  <= '0;
          end
        end
        RX_DATA: begin
          if (r_tmr != '0) begin
            r_tmr <= r_tmr - CNT_W'(1);
          end else begin
            r_shift <= {r_rx_s2, r_shift[7:1]};
            r_tmr   <= C_FULL;
            if (r_bit_idx == 3'd7) r_rx_state <= RX_STOP;
            else                   r_bit_idx  <= r_bit_idx + 3'd1;
          end
        end
        RX_STOP: begin
          if (r_tmr != '0) begin
            r_tmr <= r_tmr - CNT_W'(1);
          end else begin
            if (r_rx_s2) r_byte_vld  <= 1'b1;
            else         r_frame_bad <= 1'b1;
            r_rx_state <= RX_IDLE;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // The fourth byte is never stored; it is merged with the three held bytes on the fly.
  assign w_word_full = {r_shift, r_word};

  // Word assembly, imem write sequencing and load/done control with registered outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_ld_state   <= LD_LOAD;
      r_byte_cnt   <= '0;
      r_word       <= '0;
      prog_ready_o <= 1'b0;
      imem_we_o    <= 1'b0;
      imem_addr_o  <= '0;
      imem_wdata_o <= '0;
      prog_done_o  <= 1'b0;
      core_rst_no  <= 1'b0;
      frame_err_o  <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      imem_we_o <= 1'b0;
      if (imem_we_o) imem_addr_o <= imem_addr_o + ADDR_W'(1);
      if (r_frame_bad) frame_err_o <= 1'b1;
      case (r_ld_state)
        LD_LOAD: begin
          prog_ready_o <= 1'b1;
          if (r_byte_vld) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            case (r_byte_cnt)
              2'd0: r_word[7:0]   <= r_shift;
              2'd1: r_word[15:8]  <= r_shift;
              2'd2: r_word[23:16] <= r_shift;
              default: begin
                if (w_word_full == EOP_WORD) begin
                  r_ld_state   <= LD_DONE;
                  prog_ready_o <= 1'b0;
                  prog_done_o  <= 1'b1;
                  core_rst_no  <= 1'b1;
                end else begin
                  imem_we_o    <= 1'b1;
                  imem_wdata_o <= w_word_full;
                  if (imem_addr_o == ADDR_MAX) begin
                    overflow_o   <= 1'b1;
                    r_ld_state   <= LD_DONE;
                    prog_ready_o <= 1'b0;
                    prog_done_o  <= 1'b1;
                    core_rst_no  <= 1'b1;
                  end
                end
              end
            endcase
          end
        end
        LD_DONE: begin
          if (restart_i) begin
            r_ld_state   <= LD_LOAD;
            r_byte_cnt   <= '0;
            imem_addr_o  <= '0;
            prog_ready_o <= 1'b1;
            prog_done_o  <= 1'b0;
            core_rst_no  <= 1'b0;
            frame_err_o  <= 1'b0;
            overflow_o   <= 1'b0;
          end
        end
        default: r_ld_state <= LD_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed-plus-random bench for uart_prog_loader with a byte-level reference model.
module tb_uart_prog_loader;

  localparam int          CPB = 8;
  localparam int          AW  = 2;
  localparam logic [31:0] EOP = 32'h0000_0FFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic          restart = 1'b0;
  logic          ready, we, done, core_rst_n, ferr, ovf;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;

  always #5 clk = ~clk;

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .EOP_WORD(EOP)) dut (
    .wb_clk_i    (clk),
    .wb_rst_n    (rst_n),
    .rx_i        (rx),
    .restart_i   (restart),
    .prog_ready_o(ready),
    .imem_we_o   (we),
    .imem_addr_o (addr),
    .imem_wdata_o(wdata),
    .prog_done_o (done),
    .core_rst_no (core_rst_n),
    .frame_err_o (ferr),
    .overflow_o  (ovf)
  );

  int n_checks = 0;
  int n_err    = 0;

  logic [AW+31:0] obs_q[$];
  logic [AW+31:0] exp_q[$];

  // Record every write strobe seen on the imem port.
  always @(negedge clk) begin
    if (rst_n && we) obs_q.push_back({addr, wdata});
  end

  // Reference model: plain byte stream -> words -> expected writes.
  int          m_cnt, m_addr;
  logic [31:0] m_word;
  bit          m_done, m_ovf, m_ferr;

  task automatic model_clear();
    m_cnt = 0; m_addr = 0; m_word = '0; m_done = 0; m_ovf = 0; m_ferr = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_done) return;
    m_word[8*m_cnt +: 8] = b;
    m_cnt = m_cnt + 1;
    if (m_cnt == 4) begin
      m_cnt = 0;
      if (m_word == EOP) begin
        m_done = 1;
      end else begin
        exp_q.push_back({AW'(m_addr), m_word});
        if (m_addr == (1 << AW) - 1) begin
          m_ovf  = 1;
          m_done = 1;
        end
        m_addr = (m_addr + 1) % (1 << AW);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    rx = 1'b0; tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i]; tick(CPB);
    end
    rx = good_stop; tick(CPB);
    rx = 1'b1;
    if (!good_stop) tick(CPB);
    tick(3);
    if (good_stop) model_byte(b);
    else           m_ferr = 1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == EOP) w = w ^ 32'h1;
    return w;
  endfunction

  task automatic check_writes(input string tag);
    int n;
    tick(2);
    chk({tag, "_nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_write"}, 64'(obs_q[i]), 64'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_ready"},    64'(ready),      64'(!m_done));
    chk({tag, "_done"},     64'(done),       64'(m_done));
    chk({tag, "_core_rst"}, 64'(core_rst_n), 64'(m_done));
    chk({tag, "_ferr"},     64'(ferr),       64'(m_ferr));
    chk({tag, "_ovf"},      64'(ovf),        64'(m_ovf));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    tick(2);
    chk("rst_outputs", 64'({ready, we, addr, wdata, done, core_rst_n, ferr, ovf}), 64'(0));
    rst_n = 1'b1;
    model_clear();
    tick(1);
    chk("rst_ready_after_release", 64'(ready), 64'(1));
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    model_clear();
    tick(3);

    // Reset values, then one word with a restart pulse that must be ignored in LOAD.
    do_reset();
    send_byte(8'h13, 1'b1);
    send_byte(8'h05, 1'b1);
    restart = 1'b1; tick(1); restart = 1'b0;
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    chk("t1_model_word", 64'(exp_q.size() == 1 ? exp_q[0] : '0), 64'({2'd0, 32'h0000_0513}));
    check_writes("t1");
    check_flags("t1");

    // Two words then the marker; bytes after the marker are ignored.
    do_reset();
    send_word(32'h0050_0093);
    send_word(32'h00A0_0113);
    send_word(EOP);
    check_writes("t2");
    check_flags("t2");
    send_word(rand_word());
    check_writes("t2_after_done");
    check_flags("t2_after_done");

    // Short low glitch must not produce a byte.
    do_reset();
    rx = 1'b0; tick(3); rx = 1'b1; tick(20);
    send_byte(8'hAA, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1);
    check_writes("t3");
    check_flags("t3");

    // Frame error: byte discarded, sticky flag, next word lands at address 0.
    do_reset();
    send_byte(8'h55, 1'b0);
    check_flags("t4_ferr");
    send_word(rand_word());
    check_writes("t4");
    check_flags("t4");

    // Fill memory, overflow, ignored fifth word, restart and reload.
    do_reset();
    for (int i = 0; i < 4; i++) send_word(rand_word());
    check_writes("t5_fill");
    check_flags("t5_fill");
    send_word(rand_word());
    check_writes("t5_ignored");
    restart = 1'b1; tick(1); restart = 1'b0;
    model_clear();
    tick(1);
    check_flags("t5_restart");
    send_word(rand_word());
    check_writes("t5_reload");
    check_flags("t5_reload");

    // Reset in the middle of a word drops the partial bytes.
    do_reset();
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b1);
    do_reset();
    send_word(rand_word());
    check_writes("t6");
    check_flags("t6");

    // Random program of a few words terminated by the marker.
    do_reset();
    for (int i = 0; i < 3; i++) send_word(rand_word());
    send_word(EOP);
    check_writes("t7");
    check_flags("t7");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
